dpram: RTL and testbench

DPRAM -- requirements
Module: dpram

---
 rtl/dpram_pkg.sv | 6 +
 rtl/intf.sv | 25 ++
 rtl/dpram.sv | 38 +++
 tb/tb_dpram.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared sizing defaults for the dual-port RAM, its interface and its bench.
package dpram_pkg;
   localparam int unsigned DPRAM_DATA_WIDTH = 8;
   localparam int unsigned DPRAM_ADDR_WIDTH = 4;
   localparam int unsigned DPRAM_DEPTH      = 1 << DPRAM_ADDR_WIDTH;
endpackage

// File: rtl/intf.sv
// Signal bundle for the dual-port RAM; the bench side drives inputs and samples data_out.
interface intf
   import dpram_pkg::*;
(
   input logic clk
);
   logic                        reset;
   logic                        wr_en;
   logic                        rd_en;
   logic [DPRAM_ADDR_WIDTH-1:0] wr_addr;
   logic [DPRAM_ADDR_WIDTH-1:0] rd_addr;
   logic [DPRAM_DATA_WIDTH-1:0] data_in;
   logic [DPRAM_DATA_WIDTH-1:0] data_out;

   modport tb_mod_port (
      input  clk,
      input  data_out,
      output reset,
      output wr_en,
      output rd_en,
      output wr_addr,
      output rd_addr,
      output data_in
   );
endinterface

// File: rtl/dpram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port,
// read-first on same-address collision, synchronous clear of all words.
module dpram
   import dpram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DPRAM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DPRAM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Read samples the pre-edge word, so a same-address write lands after the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         data_out <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_addr] <= data_in;
         end
         if (rd_en) begin
            data_out <= mem[rd_addr];
         end
      end
   end
endmodule

// File: tb/tb_dpram.sv
// Directed and randomised checks of dpram through the intf bundle.
module tb_dpram;
   import dpram_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   intf u_if (.clk(clk));

   dpram dut (
      .clk      (clk),
      .reset    (u_if.reset),
      .wr_en    (u_if.wr_en),
      .rd_en    (u_if.rd_en),
      .wr_addr  (u_if.wr_addr),
      .rd_addr  (u_if.rd_addr),
      .data_in  (u_if.data_in),
      .data_out (u_if.data_out)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [7:0] ref_mem [16];
   logic [7:0] ref_out;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the reference, land 1 time unit past the edge.
   task automatic cyc(input logic rst, input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic re, input logic [3:0] ra);
      u_if.reset   = rst;
      u_if.wr_en   = we;
      u_if.wr_addr = wa;
      u_if.data_in = wd;
      u_if.rd_en   = re;
      u_if.rd_addr = ra;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
         ref_out = 8'h00;
      end else begin
         if (re) ref_out = ref_mem[ra];
         if (we) ref_mem[wa] = wd;
      end
      #1;
   endtask

   initial begin
      ref_out = 8'h00;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

      // Two reset cycles, then every word reads back zero
      cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
      check("reset_out", u_if.data_out, 8'h00);
      for (int a = 0; a < 16; a++) begin
         cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
         check($sformatf("reset_rd%0d", a), u_if.data_out, 8'h00);
      end

      // Write then read back, including top address
      cyc(1'b0, 1'b1, 4'd3,  8'hA5, 1'b0, 4'd0);
      cyc(1'b0, 1'b1, 4'd15, 8'h5A, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3);
      check("wr_rd3", u_if.data_out, 8'hA5);
      cyc(1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15);
      check("wr_rd15", u_if.data_out, 8'h5A);

      // Same-address collision returns the old word
      cyc(1'b0, 1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
      cyc(1'b0, 1'b1, 4'd7, 8'h22, 1'b1, 4'd7);
      check("collide_old", u_if.data_out, 8'h11);
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
      check("collide_new", u_if.data_out, 8'h22);

      // Independent ports in one cycle
      cyc(1'b0, 1'b1, 4'd1, 8'h33, 1'b1, 4'd3);
      check("concur_rd3", u_if.data_out, 8'hA5);
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1);
      check("concur_rd1", u_if.data_out, 8'h33);

      // Hold with rd_en low, while writes continue
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 4'(k + 8), 8'(8'h40 + k), 1'b0, 4'd1);
         check($sformatf("hold%0d", k), u_if.data_out, 8'h33);
      end
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
      check("hold_wr9", u_if.data_out, 8'h41);

      // Reset raised between edges must not act before the next edge
      u_if.reset = 1'b1;
      #2;
      check("reset_sync", u_if.data_out, 8'h41);

      // Mid-operation reset beats a concurrent write and read
      cyc(1'b1, 1'b1, 4'd2, 8'hFF, 1'b1, 4'd9);
      check("midrst_out", u_if.data_out, 8'h00);
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
      check("midrst_rd2", u_if.data_out, 8'h00);
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
      check("midrst_rd3", u_if.data_out, 8'h00);
      cyc(1'b0, 1'b1, 4'd5, 8'h77, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
      check("postrst_rd5", u_if.data_out, 8'h77);

      // Random traffic against the reference model
      for (int n = 0; n < 1000; n++) begin
         cyc(1'($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom),
             8'($urandom), 1'($urandom), 4'($urandom));
         check("random", u_if.data_out, ref_out);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Backstop against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
